// File: rtl/stereo_delay_scheduler.sv
// stereo_delay_scheduler: shares one single-port SPRAM between two circular
// delay lines. Each channel strobe queues a sample; the controller writes it
// into the channel's region, reads back the sample `delay` positions older
// and returns it with a one-cycle valid strobe.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pkt{0,1}_i / pktChanged{0,1}_i    input samples and their strobes
//   delay{0,1}_i                      requested delay in samples
//   spram_we_o/ad_o/di_o, spram_do_i  SPRAM port (read data 1-cycle latency)
//   pktDelayed{0,1}_o                 delayed samples, held between updates
//   pktDelayedChanged{0,1}_o          one-cycle valid strobes
//   overrun_o                         sticky: strobe arrived while pending
module stereo_delay_scheduler #(
  parameter int BUF_DEPTH  = 4410,
  parameter int PKT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PKT_WIDTH-1:0]  pkt0_i,
  input  logic [PKT_WIDTH-1:0]  pkt1_i,
  input  logic                  pktChanged0_i,
  input  logic                  pktChanged1_i,
  input  logic [ADDR_WIDTH-1:0] delay0_i,
  input  logic [ADDR_WIDTH-1:0] delay1_i,
  output logic                  spram_we_o,
  output logic [ADDR_WIDTH-1:0] spram_ad_o,
  output logic [PKT_WIDTH-1:0]  spram_di_o,
  input  logic [PKT_WIDTH-1:0]  spram_do_i,
  output logic [PKT_WIDTH-1:0]  pktDelayed0_o,
  output logic [PKT_WIDTH-1:0]  pktDelayed1_o,
  output logic                  pktDelayedChanged0_o,
  output logic                  pktDelayedChanged1_o,
  output logic                  overrun_o
);

  // Parameter legality: both regions must fit the 16K-word SPRAM.
  if (BUF_DEPTH < 1 || 2 * BUF_DEPTH > 16384) begin : g_bad_depth
    $fatal(1, "stereo_delay_scheduler: 2*BUF_DEPTH must be <= 16384");
  end
  if (PKT_WIDTH != 16) begin : g_bad_pkt
    $fatal(1, "stereo_delay_scheduler: PKT_WIDTH must be 16");
  end
  if (ADDR_WIDTH != 14) begin : g_bad_addr
    $fatal(1, "stereo_delay_scheduler: ADDR_WIDTH must be 14");
  end

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] D_MAX   = ADDR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE1   = ADDR_WIDTH'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = AW1'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t                state, state_nxt;
  logic                  gnt, last_grant;
  logic                  pending0, pending1;
  logic [PKT_WIDTH-1:0]  hold0, hold1;
  logic [ADDR_WIDTH-1:0] wp0, wp1, d_reg;

  logic                  any_pending, tie, arb_ch, take_grant;
  logic [ADDR_WIDTH-1:0] wp_sel, wp_adv, base_sel, delay_sel, d_clamp;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [PKT_WIDTH-1:0]  hold_sel;
  logic [ADDR_WIDTH:0]   wp_x, d_x, rp_x;
  logic                  unused_rp_msb;

  // Arbitration: a lone request wins; a tie goes to the loser of the last tie.
  assign any_pending = pending0 | pending1;
  assign tie         = pending0 & pending1;
  assign arb_ch      = tie ? ~last_grant : pending1;
  assign take_grant  = any_pending && (state == IDLE || state == CAPTURE);

  // Granted-channel views.
  assign wp_sel    = gnt ? wp1 : wp0;
  assign base_sel  = gnt ? BASE1 : '0;
  assign hold_sel  = gnt ? hold1 : hold0;
  assign delay_sel = gnt ? delay1_i : delay0_i;
  assign d_clamp   = (delay_sel > D_MAX) ? D_MAX : delay_sel;
  assign wp_adv    = (wp_sel == D_MAX) ? '0 : wp_sel + ADDR_WIDTH'(1);

  // Read pointer, one bit wider so wp + BUF_DEPTH cannot overflow.
  always_comb begin
    wp_x = {1'b0, wp_sel};
    d_x  = {1'b0, d_reg};
    if (wp_x >= d_x) rp_x = wp_x - d_x;
    else             rp_x = wp_x + DEPTH_X - d_x;
  end
  assign unused_rp_msb = rp_x[ADDR_WIDTH];

  assign wr_addr = base_sel + wp_sel;
  assign rd_addr = base_sel + rp_x[ADDR_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = any_pending ? WRITE : IDLE;
      WRITE:   state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = any_pending ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SPRAM port drive; write enable is killed by reset in the same cycle.
  always_comb begin
    spram_we_o = 1'b0;
    spram_ad_o = '0;
    spram_di_o = '0;
    case (state)
      WRITE: begin
        spram_we_o = !rst;
        spram_ad_o = wr_addr;
        spram_di_o = hold_sel;
      end
      READ:    spram_ad_o = rd_addr;
      CAPTURE: spram_ad_o = '0;
      default: spram_ad_o = '0;
    endcase
  end

  // Capture, grant, pointer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt                  <= 1'b0;
      last_grant           <= 1'b1;
      pending0             <= 1'b0;
      pending1             <= 1'b0;
      hold0                <= '0;
      hold1                <= '0;
      wp0                  <= '0;
      wp1                  <= '0;
      d_reg                <= '0;
      overrun_o            <= 1'b0;
      pktDelayed0_o        <= '0;
      pktDelayed1_o        <= '0;
      pktDelayedChanged0_o <= 1'b0;
      pktDelayedChanged1_o <= 1'b0;
    end else begin
      pktDelayedChanged0_o <= 1'b0;
      pktDelayedChanged1_o <= 1'b0;

      // A new strobe re-arms pending even on the edge that clears it.
      pending0 <= pktChanged0_i | (pending0 & ~(state == WRITE && !gnt));
      pending1 <= pktChanged1_i | (pending1 & ~(state == WRITE && gnt));
      if (pktChanged0_i) hold0 <= pkt0_i;
      if (pktChanged1_i) hold1 <= pkt1_i;
      if ((pktChanged0_i && pending0) || (pktChanged1_i && pending1))
        overrun_o <= 1'b1;

      if (take_grant) begin
        gnt <= arb_ch;
        if (tie) last_grant <= arb_ch;
      end

      if (state == WRITE) d_reg <= d_clamp;

      if (state == CAPTURE) begin
        if (gnt) begin
          pktDelayed1_o        <= spram_do_i;
          pktDelayedChanged1_o <= 1'b1;
          wp1                  <= wp_adv;
        end else begin
          pktDelayed0_o        <= spram_do_i;
          pktDelayedChanged0_o <= 1'b1;
          wp0                  <= wp_adv;
        end
      end
    end
  end

endmodule
